// File: rtl/multicycle_control_if.sv
// Shared memory-port handshake between the multi-cycle control unit and the memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RISC-V core: sequences fetch/decode/exec/mem/wb,
// holds memory requests across wait states with a timeout trap, and counts retirements.
module multicycle_control #(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 branch,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [2:0]           state,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     instret
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5
  } cls_e;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [2:0]         alu_q, alu_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  cls_e               dec_cls;
  logic [2:0]         dec_alu;
  logic               timeout_c;
  logic               retire_c;
  logic               mem_req_o, mem_we_o, iord_o;
  logic [2:0]         alu_o;

  // Instruction class decode; only consumed while in DECODE.
  always_comb begin
    dec_cls = CLS_NONE;
    dec_alu = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            dec_cls = CLS_R;
            dec_alu = funct7_5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            dec_cls = CLS_R;
            dec_alu = ALU_AND;
          end
          3'b110: begin
            dec_cls = CLS_R;
            dec_alu = ALU_OR;
          end
          default: dec_cls = CLS_NONE;
        endcase
      end
      OP_I: begin
        case (funct3)
          3'b000: begin
            dec_cls = CLS_I;
            dec_alu = ALU_ADD;
          end
          3'b111: begin
            dec_cls = CLS_I;
            dec_alu = ALU_AND;
          end
          3'b110: begin
            dec_cls = CLS_I;
            dec_alu = ALU_OR;
          end
          default: dec_cls = CLS_NONE;
        endcase
      end
      OP_LOAD:   dec_cls = (funct3 == 3'b010) ? CLS_LOAD : CLS_NONE;
      OP_STORE:  dec_cls = (funct3 == 3'b010) ? CLS_STORE : CLS_NONE;
      OP_BRANCH: dec_cls = (funct3 == 3'b000) ? CLS_BRANCH : CLS_NONE;
      default:   dec_cls = CLS_NONE;
    endcase
  end

  // A ready in the limit cycle still completes the request, so timeout only fires when not ready.
  assign timeout_c = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT)) && !mem.mem_ready;

  // Next-state and control outputs.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_d      = alu_q;
    wait_d     = '0;
    cause_d    = cause_q;
    retire_c   = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    iord_o     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_o      = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_cls == CLS_NONE) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          cls_d   = dec_cls;
          alu_d   = dec_alu;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (cls_q)
          CLS_R: begin
            alu_o   = alu_q;
            state_d = S_WB;
          end
          CLS_I: begin
            alu_src_b = 1'b1;
            alu_o     = alu_q;
            state_d   = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          CLS_BRANCH: begin
            alu_o    = ALU_SUB;
            branch   = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (cls_q == CLS_STORE);
        if (mem.mem_ready) begin
          if (cls_q == CLS_STORE) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LOAD);
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        alu_o = 3'b000;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    instret_d = retire_c ? (instret_q + CNT_W'(1)) : instret_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NONE;
      alu_q     <= ALU_ADD;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign mem.mem_req = mem_req_o;
  assign mem.mem_we  = mem_we_o;
  assign mem.iord    = iord_o;
  assign alu_op      = ALUOP_W'(alu_o);
  assign state       = state_q;
  assign trap_cause  = cause_q;
  assign instret     = instret_q;

endmodule
